// File: rtl/pipe_code_gen.sv
// Gap-code producer for the scrolling playfield: a shift buffer of per-column
// pipe codes, LFSR-driven pipe insertion at fixed spacing, and a score counter.
module pipe_code_gen #(
  parameter int          NUM_COLS     = 16,
  parameter int          PIPE_SPACING = 4,
  parameter logic [7:0]  SEED         = 8'hA5,
  parameter logic [2:0]  EMPTY_CODE   = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       step,
  input  logic [3:0] col_sel,
  output logic [2:0] col_code,
  output logic [2:0] new_code,
  output logic       new_valid,
  output logic [7:0] pipe_count
);

  localparam logic [7:0] LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam int         CNT_W     = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_SPACING - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    lfsr_next = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // 3'b111 would collide with the empty marker, so it folds onto gap 0.
  function automatic logic [2:0] pipe_code(input logic [7:0] s);
    pipe_code = (s[2:0] == 3'b111) ? 3'b000 : s[2:0];
  endfunction

  logic [2:0]       col_q [NUM_COLS];
  logic [2:0]       col_d [NUM_COLS];
  logic [7:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic [7:0]       pipe_count_q, pipe_count_d;
  logic [2:0]       col_code_q, col_code_d;
  logic [2:0]       pend_code_q, pend_code_d;
  logic             pend_valid_q, pend_valid_d;
  logic [2:0]       new_code_q, new_code_d;
  logic             new_valid_q, new_valid_d;

  logic             step_pulse_s;
  logic             scroll_s;
  logic [2:0]       ins_s;

  // Scroll decision, buffer shift, insertion and score update.
  always_comb begin
    step_pulse_s = step & ~step_q;
    scroll_s     = step_pulse_s & enable;
    step_d       = step;
    col_d        = col_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    pipe_count_d = pipe_count_q;

    if (cnt_q == CNT_ZERO) begin
      ins_s = pipe_code(lfsr_q);
    end else begin
      ins_s = EMPTY_CODE;
    end

    if (scroll_s) begin
      for (int i = 0; i < NUM_COLS - 1; i++) begin
        col_d[i] = col_q[i+1];
      end
      col_d[NUM_COLS-1] = ins_s;
      lfsr_d            = lfsr_next(lfsr_q);
      if (cnt_q == CNT_LAST) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if ((col_q[0] != EMPTY_CODE) && (pipe_count_q != 8'hFF)) begin
        pipe_count_d = pipe_count_q + 8'd1;
      end else begin
        pipe_count_d = pipe_count_q;
      end
    end else begin
      col_d = col_q;
    end
  end

  // The inserted code is staged one edge, then presented with its valid pulse.
  always_comb begin
    pend_valid_d = scroll_s;
    if (scroll_s) begin
      pend_code_d = ins_s;
    end else begin
      pend_code_d = pend_code_q;
    end
    new_valid_d = pend_valid_q;
    if (pend_valid_q) begin
      new_code_d = pend_code_q;
    end else begin
      new_code_d = new_code_q;
    end
  end

  // Read port samples the pre-scroll buffer every clock.
  always_comb begin
    if (int'(col_sel) < NUM_COLS) begin
      col_code_d = col_q[col_sel];
    end else begin
      col_code_d = EMPTY_CODE;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        col_q[i] <= EMPTY_CODE;
      end
      lfsr_q       <= LFSR_INIT;
      cnt_q        <= CNT_ZERO;
      step_q       <= 1'b0;
      pipe_count_q <= 8'd0;
      col_code_q   <= EMPTY_CODE;
      pend_code_q  <= EMPTY_CODE;
      pend_valid_q <= 1'b0;
      new_code_q   <= EMPTY_CODE;
      new_valid_q  <= 1'b0;
    end else begin
      col_q        <= col_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      pipe_count_q <= pipe_count_d;
      col_code_q   <= col_code_d;
      pend_code_q  <= pend_code_d;
      pend_valid_q <= pend_valid_d;
      new_code_q   <= new_code_d;
      new_valid_q  <= new_valid_d;
    end
  end

  assign col_code   = col_code_q;
  assign new_code   = new_code_q;
  assign new_valid  = new_valid_q;
  assign pipe_count = pipe_count_q;

endmodule

// File: tb/tb_pipe_code_gen.sv
// Directed bench for pipe_code_gen: reset state, LFSR insertion sequence,
// step edge detection, pause behaviour, score saturation and async reset.
module tb_pipe_code_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       step;
  logic [3:0] col_sel;
  logic [2:0] col_code;
  logic [2:0] new_code;
  logic       new_valid;
  logic [7:0] pipe_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_code_gen dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .step       (step),
    .col_sel    (col_sel),
    .col_code   (col_code),
    .new_code   (new_code),
    .new_valid  (new_valid),
    .pipe_count (pipe_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One step pulse; returns the valid level right after the scroll edge and
  // the code/valid seen one edge later.
  task automatic do_step(output logic early_valid, output logic valid, output logic [2:0] code);
    step = 1'b1;
    tick();
    step = 1'b0;
    early_valid = new_valid;
    tick();
    valid = new_valid;
    code  = new_code;
  endtask

  task automatic read_col(input int c, output logic [2:0] v);
    col_sel = c[3:0];
    tick();
    v = col_code;
  endtask

  task automatic test_reset();
    logic [2:0] v;
    n_checks++;
    if (pipe_count !== 8'd0) begin n_fail++; $display("FAIL reset_pipe_count got %0d want 0", pipe_count); end
    n_checks++;
    if (new_valid !== 1'b0) begin n_fail++; $display("FAIL reset_new_valid got %0b want 0", new_valid); end
    n_checks++;
    if (new_code !== 3'd7) begin n_fail++; $display("FAIL reset_new_code got %0d want 7", new_code); end
    for (int c = 0; c < 16; c++) begin
      read_col(c, v);
      n_checks++;
      if (v !== 3'd7) begin n_fail++; $display("FAIL reset_col%0d got %0d want 7", c, v); end
    end
  endtask

  task automatic test_single_step();
    logic e, vl;
    logic [2:0] code, v;
    enable = 1'b1;
    do_step(e, vl, code);
    n_checks++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %0b want 0", e); end
    n_checks++;
    if (vl !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", vl); end
    n_checks++;
    if (code !== 3'd5) begin n_fail++; $display("FAIL single_code got %0d want 5", code); end
    tick();
    n_checks++;
    if (new_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_width got %0b want 0", new_valid); end
    for (int c = 0; c < 16; c++) begin
      read_col(c, v);
      n_checks++;
      if (v !== ((c == 15) ? 3'd5 : 3'd7)) begin
        n_fail++; $display("FAIL single_col%0d got %0d want %0d", c, v, (c == 15) ? 5 : 7);
      end
    end
  endtask

  task automatic test_sequence();
    logic e, vl;
    logic [2:0] code, v;
    logic [2:0] exp_codes [4] = '{3'd7, 3'd7, 3'd7, 3'd4};
    logic [2:0] exp_cols  [5] = '{3'd5, 3'd7, 3'd7, 3'd7, 3'd4};
    for (int k = 0; k < 4; k++) begin
      do_step(e, vl, code);
      n_checks++;
      if (vl !== 1'b1 || code !== exp_codes[k]) begin
        n_fail++; $display("FAIL seq_step%0d got valid=%0b code=%0d want valid=1 code=%0d", k + 2, vl, code, exp_codes[k]);
      end
    end
    for (int c = 11; c < 16; c++) begin
      read_col(c, v);
      n_checks++;
      if (v !== exp_cols[c-11]) begin n_fail++; $display("FAIL seq_col%0d got %0d want %0d", c, v, exp_cols[c-11]); end
    end
  endtask

  task automatic test_hold_and_pause();
    logic e, vl;
    logic [2:0] code, v;
    logic [2:0] exp_codes [3] = '{3'd7, 3'd7, 3'd6};
    int pulses = 0;
    step = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (new_valid === 1'b1) pulses++;
    end
    step = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (new_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL hold_scrolls got %0d want 1", pulses); end
    read_col(14, v);
    n_checks++;
    if (v !== 3'd4) begin n_fail++; $display("FAIL hold_col14 got %0d want 4", v); end
    read_col(10, v);
    n_checks++;
    if (v !== 3'd5) begin n_fail++; $display("FAIL hold_col10 got %0d want 5", v); end

    enable = 1'b0;
    pulses = 0;
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (new_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL pause_valid got %0d pulses want 0", pulses); end
    read_col(14, v);
    n_checks++;
    if (v !== 3'd4) begin n_fail++; $display("FAIL pause_col14 got %0d want 4", v); end
    read_col(15, v);
    n_checks++;
    if (v !== 3'd7) begin n_fail++; $display("FAIL pause_col15 got %0d want 7", v); end

    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_step(e, vl, code);
      n_checks++;
      if (vl !== 1'b1 || code !== exp_codes[k]) begin
        n_fail++; $display("FAIL resume_step%0d got valid=%0b code=%0d want valid=1 code=%0d", k + 7, vl, code, exp_codes[k]);
      end
    end
  endtask

  task automatic test_pipe_count();
    logic e, vl;
    logic [2:0] code;
    apply_reset();
    enable = 1'b1;
    for (int k = 0; k < 16; k++) do_step(e, vl, code);
    n_checks++;
    if (pipe_count !== 8'd0) begin n_fail++; $display("FAIL score_after16 got %0d want 0", pipe_count); end
    do_step(e, vl, code);
    n_checks++;
    if (pipe_count !== 8'd1) begin n_fail++; $display("FAIL score_after17 got %0d want 1", pipe_count); end
    for (int k = 0; k < 4; k++) do_step(e, vl, code);
    n_checks++;
    if (pipe_count !== 8'd2) begin n_fail++; $display("FAIL score_after21 got %0d want 2", pipe_count); end
    for (int k = 0; k < 1979; k++) do_step(e, vl, code);
    n_checks++;
    if (pipe_count !== 8'd255) begin n_fail++; $display("FAIL score_saturate got %0d want 255", pipe_count); end
  endtask

  task automatic test_async_reset();
    logic e, vl;
    logic [2:0] code, v;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (pipe_count !== 8'd0) begin n_fail++; $display("FAIL areset_pipe_count got %0d want 0", pipe_count); end
    n_checks++;
    if (new_valid !== 1'b0) begin n_fail++; $display("FAIL areset_new_valid got %0b want 0", new_valid); end
    n_checks++;
    if (new_code !== 3'd7) begin n_fail++; $display("FAIL areset_new_code got %0d want 7", new_code); end
    n_checks++;
    if (col_code !== 3'd7) begin n_fail++; $display("FAIL areset_col_code got %0d want 7", col_code); end
    tick();
    reset = 1'b0;
    tick();
    do_step(e, vl, code);
    n_checks++;
    if (vl !== 1'b1 || code !== 3'd5) begin
      n_fail++; $display("FAIL areset_first_step got valid=%0b code=%0d want valid=1 code=5", vl, code);
    end
    read_col(15, v);
    n_checks++;
    if (v !== 3'd5) begin n_fail++; $display("FAIL areset_col15 got %0d want 5", v); end
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    step    = 1'b0;
    col_sel = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_single_step();
    test_sequence();
    test_hold_and_pause();
    test_pipe_count();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_code_gen.md
Name: pipe_code_gen

Overview:
Producer side of the column-pattern path. It generates the per-column 3-bit gap codes that the column pattern decoder expands into 16-bit LED column images. It holds a scrolling 16-column buffer of codes and inserts pseudo-random pipes at fixed spacing. It also counts pipes that scroll off the left edge, which gives the score.

Parameters:
NUM_COLS, 16, number of columns in the scroll buffer (playfield width)
PIPE_SPACING, 4, steps between consecutive pipe insertions (one pipe, then PIPE_SPACING-1 empty columns)
SEED, 8'hA5, LFSR reset value; a value of 0 is replaced by 8'h01
EMPTY_CODE, 3'b111, code meaning "no pipe in this column"

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  scrolling allowed (low = game paused/over)
step  input  1  scroll request level; internally rising-edge detected
col_sel  input  4  column read address, 0 = leftmost
col_code  output  3  registered code of column col_sel, fed to the column pattern decoder
new_code  output  3  code just inserted at column NUM_COLS-1
new_valid  output  1  one-cycle pulse accompanying new_code
pipe_count  output  8  pipes scrolled off column 0, saturating

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-operation:
  - all buffer entries = EMPTY_CODE
  - lfsr = SEED (or 8'h01 if SEED = 0)
  - spacing counter = 0, edge-detect register = 0
  - col_code = EMPTY_CODE, new_code = EMPTY_CODE, new_valid = 0, pipe_count = 0
- step_pulse = step & ~step_q, with step_q registered every clock. Holding step high yields exactly one step.
- A scroll occurs on a clock where step_pulse & enable. step_pulse with enable low is discarded, not queued.
- On a scroll, all in the same edge:
  - col[i] <= col[i+1] for i = 0..NUM_COLS-2.
  - col[NUM_COLS-1] <= ins. ins = (lfsr[2:0] == 3'b111) ? 3'b000 : lfsr[2:0] when spacing counter == 0, else EMPTY_CODE.
  - Spacing counter wraps: counter <= (counter == PIPE_SPACING-1) ? 0 : counter+1.
  - lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. The LFSR advances only on scrolls, so the sequence is deterministic.
  - If the old col[0] != EMPTY_CODE and pipe_count != 255, pipe_count increments. It holds at 255.
  - new_code <= ins and new_valid <= 1 on the edge after the scroll edge (one-cycle latency). new_valid is 0 otherwise.
- Read port: col_code <= col[col_sel] every clock, regardless of enable, giving one-cycle read latency.
  - col_sel >= NUM_COLS returns EMPTY_CODE.
  - A read and a scroll in the same cycle return the pre-scroll value.
- Valid pipe codes are 0..6; EMPTY_CODE is never produced as a pipe.

Test Plan:
- Reset, then sweep col_sel 0..15 -> col_code = 3'b111 for every column one cycle later; pipe_count = 0, new_valid = 0.
- enable = 1, single step pulse -> next cycle new_valid = 1 and new_code = 5 (from lfsr A5); col15 reads 5, col0..14 read 7.
- Five step pulses -> new_code sequence 5, 7, 7, 7, 4 (lfsr A5, 4A, 95, 2A, 54); col11 = 5, col15 = 4.
- step held high 10 cycles -> exactly one scroll. step pulse with enable = 0 -> buffer and lfsr unchanged, no new_valid.
- 17 step pulses from reset -> pipe_count = 1 after the 17th, when the first pipe leaves col0. Continue for 2000 steps -> pipe_count saturates at 255.
- Assert reset asynchronously between clock edges mid-run -> outputs return to reset values before the next edge. After release, the first step reproduces new_code = 5.
